// File: rtl/cla_serial_adder.sv
// cla_serial_adder: multi-cycle WIDTH-bit adder that processes one BLOCK-bit
// carry-lookahead slice per clock, least significant slice first. The carry
// between slices lives in a register. start/busy/done handshake.
// Optional build macro: CLA_SERIAL_OVERFLOW_EN adds the registered signed
// overflow output.
module cla_serial_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef CLA_SERIAL_OVERFLOW_EN
    output logic             carryout,
    output logic             overflow
`else
    output logic             carryout
`endif
);

    localparam int N  = WIDTH / BLOCK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((BLOCK < 1) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
            $error("cla_serial_adder: WIDTH must be a non-zero multiple of BLOCK");
        end
    endgenerate

    // Lookahead carries for one slice, each built as a flat sum of products:
    // c[j+1] = g[j] | p[j]g[j-1] | ... | p[j]..p[1]g[0] | p[j]..p[0]c0
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] g,
        input logic [BLOCK-1:0] p,
        input logic             c0
    );
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int j = 0; j < BLOCK; j++) begin
            term = c0;
            for (int i = 0; i <= j; i++) begin
                term = term & p[i];
            end
            c[j+1] = term;
            for (int i = 0; i <= j; i++) begin
                term = g[i];
                for (int m = i + 1; m <= j; m++) begin
                    term = term & p[m];
                end
                c[j+1] = c[j+1] | term;
            end
        end
        return c;
    endfunction

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_done;
`ifdef CLA_SERIAL_OVERFLOW_EN
    logic             r_ovf;
`endif

    logic             w_accept;
    logic             w_last;
    logic [BLOCK-1:0] w_a_sl;
    logic [BLOCK-1:0] w_b_sl;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;
    logic [BLOCK-1:0] w_sum;
    logic [WIDTH-1:0] w_work_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_k == KW'(N - 1));

    // State register; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE waits for start, RUN lasts N slices
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Current slice selection, lookahead carries, slice sum and merged working sum
    always_comb begin
        w_a_sl      = '0;
        w_b_sl      = '0;
        w_work_next = r_work;
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_a_sl = r_a[i*BLOCK +: BLOCK];
                w_b_sl = r_b[i*BLOCK +: BLOCK];
            end
        end
        w_g   = w_a_sl & w_b_sl;
        w_p   = w_a_sl ^ w_b_sl;
        w_c   = cla_carries(w_g, w_p, r_carry);
        w_sum = w_p ^ w_c[BLOCK-1:0];
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_work_next[i*BLOCK +: BLOCK] = w_sum;
            end
        end
    end

    // Operand capture, per-slice accumulation and result publication on the last slice
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_work  <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
`ifdef CLA_SERIAL_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_k     <= '0;
            end else if (r_state == S_RUN) begin
                r_work  <= w_work_next;
                r_carry <= w_c[BLOCK];
                r_k     <= r_k + 1'b1;
                if (w_last) begin
                    r_k    <= '0;
                    r_s    <= w_work_next;
                    r_cout <= w_c[BLOCK];
                    r_done <= 1'b1;
`ifdef CLA_SERIAL_OVERFLOW_EN
                    // carry into the MSB differs from carry out of it
                    r_ovf  <= w_c[BLOCK] ^ w_c[BLOCK-1];
`endif
                end
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign s        = r_s;
    assign carryout = r_cout;
`ifdef CLA_SERIAL_OVERFLOW_EN
    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: scoreboard bench for cla_serial_adder. Stimulus pushes
// hand-computed results into per-instance queues; monitors pop and compare on
// every done pulse. Instances: WIDTH=16/BLOCK=4 and WIDTH=4/BLOCK=4.
module tb_cla_serial_adder;

    localparam int N16 = 4;
    localparam int N4  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, s16;
    logic        start4, cin4, busy4, done4, cout4;
    logic [3:0]  a4, b4, s4;
`ifdef CLA_SERIAL_OVERFLOW_EN
    logic        ovf16, ovf4;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
        string       name;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cla_serial_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .start    (start16),
        .a        (a16),
        .b        (b16),
        .cin      (cin16),
        .busy     (busy16),
        .done     (done16),
        .s        (s16),
`ifdef CLA_SERIAL_OVERFLOW_EN
        .carryout (cout16),
        .overflow (ovf16)
`else
        .carryout (cout16)
`endif
    );

    cla_serial_adder #(.WIDTH(4), .BLOCK(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .cin      (cin4),
        .busy     (busy4),
        .done     (done4),
        .s        (s4),
`ifdef CLA_SERIAL_OVERFLOW_EN
        .carryout (cout4),
        .overflow (ovf4)
`else
        .carryout (cout4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                check("dut16 done with empty scoreboard", {31'b0, done16}, 32'd0);
            end else begin
                e = q16.pop_front();
                check({e.name, " sum"}, {16'b0, s16}, {16'b0, e.sum});
                check({e.name, " carryout"}, {31'b0, cout16}, {31'b0, e.cout});
                check({e.name, " latency"}, cyc, e.due);
`ifdef CLA_SERIAL_OVERFLOW_EN
                check({e.name, " overflow"}, {31'b0, ovf16}, {31'b0, e.ovf});
`endif
            end
        end
    end

    // Monitor for the 4-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                check("dut4 done with empty scoreboard", {31'b0, done4}, 32'd0);
            end else begin
                e = q4.pop_front();
                check({e.name, " sum"}, {28'b0, s4}, {16'b0, e.sum});
                check({e.name, " carryout"}, {31'b0, cout4}, {31'b0, e.cout});
                check({e.name, " latency"}, cyc, e.due);
`ifdef CLA_SERIAL_OVERFLOW_EN
                check({e.name, " overflow"}, {31'b0, ovf4}, {31'b0, e.ovf});
`endif
            end
        end
    end

    // Drive one start pulse; returns at the negedge just after the accepting edge
    task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                           input logic [15:0] es, input logic ec, input logic eo,
                           input bit expect_done, input string name);
        exp_t e;
        @(negedge clk);
        a16 = ta; b16 = tb_; cin16 = tc; start16 = 1'b1;
        if (expect_done) begin
            e.sum = es; e.cout = ec; e.ovf = eo; e.due = cyc + 1 + N16; e.name = name;
            q16.push_back(e);
        end
        @(negedge clk);
        start16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = ~tc;
    endtask

    task automatic issue4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                          input logic [3:0] es, input logic ec, input logic eo,
                          input string name);
        exp_t e;
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
        e.sum = {12'b0, es}; e.cout = ec; e.ovf = eo; e.due = cyc + 1 + N4; e.name = name;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0; a4 = 4'hA; b4 = 4'h5; cin4 = ~tc;
    endtask

    // busy high for N16 cycles after acceptance, low in the done cycle
    task automatic busy_seq16(input string name);
        for (int i = 0; i < N16; i++) begin
            if (i > 0) @(negedge clk);
            check({name, " busy during run"}, {31'b0, busy16}, 32'd1);
        end
        @(negedge clk);
        check({name, " busy in done cycle"}, {31'b0, busy16}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset busy16", {31'b0, busy16}, 32'd0);
        check("reset done16", {31'b0, done16}, 32'd0);
        check("reset s16", {16'b0, s16}, 32'd0);
        check("reset carryout16", {31'b0, cout16}, 32'd0);
        check("reset busy4", {31'b0, busy4}, 32'd0);
        check("reset s4", {28'b0, s4}, 32'd0);
`ifdef CLA_SERIAL_OVERFLOW_EN
        check("reset overflow16", {31'b0, ovf16}, 32'd0);
`endif
        rst = 1'b0;

        issue16(16'h0001, 16'hFFFE, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, "t1 1+FFFE");
        busy_seq16("t1");
        issue16(16'h0001, 16'hFFFE, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "t2 1+FFFE+1");
        busy_seq16("t2");
        issue16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, "t3 7FFF+1");
        busy_seq16("t3");

        // start while busy is ignored; next start in the done cycle is accepted
        issue16(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1, "t4a 1111+2222");
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h1234; b16 = 16'h0000; cin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        check("t4 busy after ignored start", {31'b0, busy16}, 32'd1);
        @(negedge clk);
        issue16(16'h8001, 16'h8000, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b1, "t4b back-to-back");
        busy_seq16("t4b");

        // reset during RUN aborts without a done pulse
        issue16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "t5");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 abort busy", {31'b0, busy16}, 32'd0);
        check("t5 abort done", {31'b0, done16}, 32'd0);
        check("t5 abort s", {16'b0, s16}, 32'd0);
        check("t5 abort carryout", {31'b0, cout16}, 32'd0);
        repeat (8) @(negedge clk);

        issue16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1, "t6 after abort");
        busy_seq16("t6");

        // single-slice instance: latency 1
        issue4(4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0, 1'b1, "w4 7+7");
        check("w4 busy after accept", {31'b0, busy4}, 32'd1);
        @(negedge clk);
        check("w4 busy in done cycle", {31'b0, busy4}, 32'd0);
        issue4(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "w4 F+1");

        for (int i = 0; i < 40 && (q16.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("dut16 scoreboard drained", q16.size(), 32'd0);
        check("dut4 scoreboard drained", q4.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
